// File: rtl/rank_filter_3x3.sv
// 3x3 rank filter: median, minimum, maximum or centre bypass per channel.
// Three stages (row sort, column sort, select) with one shared stall enable.
module rank_filter_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     mode,
    input  logic                           in3x3_val,
    output logic                           in3x3_rdy,
    input  logic [9*DATA_WIDTH*CHANNELS-1:0] in3x3_data,
    input  logic                           in3x3_sof,
    input  logic                           in3x3_eof,
    input  logic                           in3x3_sol,
    input  logic                           in3x3_eol,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [DATA_WIDTH*CHANNELS-1:0] out_data,
    output logic                           out_sof,
    output logic                           out_eof,
    output logic                           out_sol,
    output logic                           out_eol,
    output logic [1:0]                     active_mode
);
    localparam int DW = DATA_WIDTH;
    localparam int C  = CHANNELS;

    function automatic logic [3*DW-1:0] sort3(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] c
    );
        logic [DW-1:0] lo, hi, mn, md, mx;
        lo = (b < a) ? b : a;
        hi = (b < a) ? a : b;
        mn = (c < lo) ? c : lo;
        mx = (c > hi) ? c : hi;
        md = (c > hi) ? hi : ((c < lo) ? lo : c);
        return {mx, md, mn};
    endfunction

    logic          en;
    logic          in_fire;
    logic [1:0]    beat_mode;

    logic [DW-1:0] n1_lo [C][3];
    logic [DW-1:0] n1_md [C][3];
    logic [DW-1:0] n1_hi [C][3];
    logic [DW-1:0] s1_lo [C][3];
    logic [DW-1:0] s1_md [C][3];
    logic [DW-1:0] s1_hi [C][3];
    logic [DW-1:0] s1_p4 [C];
    logic [1:0]    s1_mode;
    logic [3:0]    s1_mk;
    logic          s1_v;

    logic [DW-1:0] n2_lo [C];
    logic [DW-1:0] n2_a  [C];
    logic [DW-1:0] n2_b  [C];
    logic [DW-1:0] n2_c  [C];
    logic [DW-1:0] n2_hi [C];
    logic [DW-1:0] s2_lo [C];
    logic [DW-1:0] s2_a  [C];
    logic [DW-1:0] s2_b  [C];
    logic [DW-1:0] s2_c  [C];
    logic [DW-1:0] s2_hi [C];
    logic [DW-1:0] s2_p4 [C];
    logic [1:0]    s2_mode;
    logic [3:0]    s2_mk;
    logic          s2_v;

    logic [DW*C-1:0] n3;
    logic [3:0]      out_mk;

    assign en        = !out_val || out_rdy;
    assign in3x3_rdy = en;
    assign in_fire   = in3x3_val && en;
    // A sof beat takes the live mode; others inherit the frame's latched mode.
    assign beat_mode = in3x3_sof ? mode : active_mode;
    assign {out_sof, out_eof, out_sol, out_eol} = out_mk;

    always_comb begin
        logic [3*DW-1:0] t;
        t = '0;
        for (int c = 0; c < C; c++) begin
            for (int r = 0; r < 3; r++) begin
                t = sort3(in3x3_data[(c*9+r*3)*DW +: DW],
                          in3x3_data[(c*9+r*3+1)*DW +: DW],
                          in3x3_data[(c*9+r*3+2)*DW +: DW]);
                n1_lo[c][r] = t[0 +: DW];
                n1_md[c][r] = t[DW +: DW];
                n1_hi[c][r] = t[2*DW +: DW];
            end
        end
    end

    always_comb begin
        logic [3*DW-1:0] t;
        t = '0;
        for (int c = 0; c < C; c++) begin
            t = sort3(s1_lo[c][0], s1_lo[c][1], s1_lo[c][2]);
            n2_lo[c] = t[0 +: DW];
            n2_a[c]  = t[2*DW +: DW];
            t = sort3(s1_md[c][0], s1_md[c][1], s1_md[c][2]);
            n2_b[c]  = t[DW +: DW];
            t = sort3(s1_hi[c][0], s1_hi[c][1], s1_hi[c][2]);
            n2_c[c]  = t[0 +: DW];
            n2_hi[c] = t[2*DW +: DW];
        end
    end

    always_comb begin
        logic [3*DW-1:0] t;
        t  = '0;
        n3 = '0;
        for (int c = 0; c < C; c++) begin
            t = sort3(s2_a[c], s2_b[c], s2_c[c]);
            unique case (s2_mode)
                2'b00: n3[c*DW +: DW] = t[DW +: DW];
                2'b01: n3[c*DW +: DW] = s2_lo[c];
                2'b10: n3[c*DW +: DW] = s2_hi[c];
                2'b11: n3[c*DW +: DW] = s2_p4[c];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mode <= 2'b00;
        end else if (in_fire && in3x3_sof) begin
            active_mode <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < C; c++) begin
                for (int r = 0; r < 3; r++) begin
                    s1_lo[c][r] <= '0;
                    s1_md[c][r] <= '0;
                    s1_hi[c][r] <= '0;
                end
                s1_p4[c] <= '0;
                s2_lo[c] <= '0;
                s2_a[c]  <= '0;
                s2_b[c]  <= '0;
                s2_c[c]  <= '0;
                s2_hi[c] <= '0;
                s2_p4[c] <= '0;
            end
            s1_mode  <= 2'b00;
            s1_mk    <= '0;
            s1_v     <= 1'b0;
            s2_mode  <= 2'b00;
            s2_mk    <= '0;
            s2_v     <= 1'b0;
            out_data <= '0;
            out_mk   <= '0;
            out_val  <= 1'b0;
        end else if (en) begin
            for (int c = 0; c < C; c++) begin
                for (int r = 0; r < 3; r++) begin
                    s1_lo[c][r] <= n1_lo[c][r];
                    s1_md[c][r] <= n1_md[c][r];
                    s1_hi[c][r] <= n1_hi[c][r];
                end
                s1_p4[c] <= in3x3_data[(c*9+4)*DW +: DW];
                s2_lo[c] <= n2_lo[c];
                s2_a[c]  <= n2_a[c];
                s2_b[c]  <= n2_b[c];
                s2_c[c]  <= n2_c[c];
                s2_hi[c] <= n2_hi[c];
                s2_p4[c] <= s1_p4[c];
            end
            s1_mode  <= beat_mode;
            s1_mk    <= {in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol};
            s1_v     <= in3x3_val;
            s2_mode  <= s1_mode;
            s2_mk    <= s1_mk;
            s2_v     <= s1_v;
            out_data <= n3;
            out_mk   <= s2_mk;
            out_val  <= s2_v;
        end
    end
endmodule

// File: tb/tb_rank_filter_3x3.sv
// Scoreboard bench for rank_filter_3x3 (two channels, 8-bit samples).
// Expected results come from a sort-based model of the 3x3 window.
module tb_rank_filter_3x3;
    localparam int DW = 8;
    localparam int C  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      mode = 2'b00;
    logic            in3x3_val = 1'b0;
    logic            in3x3_rdy;
    logic [9*DW*C-1:0] in3x3_data = '0;
    logic            in3x3_sof = 1'b0;
    logic            in3x3_eof = 1'b0;
    logic            in3x3_sol = 1'b0;
    logic            in3x3_eol = 1'b0;
    logic            out_val;
    logic            out_rdy = 1'b1;
    logic [DW*C-1:0] out_data;
    logic            out_sof, out_eof, out_sol, out_eol;
    logic [1:0]      active_mode;

    rank_filter_3x3 #(.DATA_WIDTH(DW), .CHANNELS(C)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in3x3_val(in3x3_val), .in3x3_rdy(in3x3_rdy),
        .in3x3_data(in3x3_data),
        .in3x3_sof(in3x3_sof), .in3x3_eof(in3x3_eof),
        .in3x3_sol(in3x3_sol), .in3x3_eol(in3x3_eol),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof),
        .out_sol(out_sol), .out_eol(out_eol),
        .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*C-1:0] d;
        logic [3:0]      m;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic [1:0] cur_mode = 2'b00;
    logic send_done;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_ch(input logic [9*DW-1:0] w,
                                             input logic [1:0] md);
        int s[9];
        int t;
        for (int p = 0; p < 9; p++) s[p] = int'(w[p*DW +: DW]);
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        case (md)
            2'b00: return DW'(s[4]);
            2'b01: return DW'(s[0]);
            2'b10: return DW'(s[8]);
            default: return w[4*DW +: DW];
        endcase
    endfunction

    function automatic logic [DW*C-1:0] ref_all(input logic [9*DW*C-1:0] d,
                                                input logic [1:0] md);
        logic [DW*C-1:0] r;
        r = '0;
        for (int c = 0; c < C; c++)
            r[c*DW +: DW] = ref_ch(d[c*9*DW +: 9*DW], md);
        return r;
    endfunction

    function automatic logic [9*DW-1:0] pack9(input int v[9]);
        logic [9*DW-1:0] r;
        for (int p = 0; p < 9; p++) r[p*DW +: DW] = DW'(v[p]);
        return r;
    endfunction

    function automatic logic [9*DW*C-1:0] rnd_data();
        logic [9*DW*C-1:0] r;
        for (int i = 0; i < 9*C; i++) begin
            // Small value range forces frequent ties.
            if ($urandom_range(0, 1) == 0) r[i*DW +: DW] = DW'($urandom_range(0, 3));
            else r[i*DW +: DW] = DW'($urandom);
        end
        return r;
    endfunction

    // Called #1 after a rising edge; returns #1 after the transfer edge.
    task automatic send(input logic [9*DW*C-1:0] d, input logic [3:0] mk,
                        input logic [1:0] md);
        int n;
        in3x3_data = d;
        {in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol} = mk;
        mode = md;
        in3x3_val = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in3x3_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in3x3_rdy) begin
            chk("send_timeout", 32'(in3x3_rdy), 32'd1);
            @(posedge clk); #1;
        end else begin
            if (mk[3]) cur_mode = md;
            sb.push_back('{d: ref_all(d, cur_mode), m: mk});
            @(posedge clk); #1;
            if (mk[3]) chk("active_mode", 32'(active_mode), 32'(cur_mode));
        end
        in3x3_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin : monitor
        logic            stall_prev;
        logic [DW*C-1:0] held_d;
        logic [3:0]      held_m;
        exp_t            e;
        stall_prev = 1'b0;
        held_d = '0;
        held_m = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_val", 32'(out_val), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(held_d));
                    chk("hold_mk", 32'({out_sof, out_eof, out_sol, out_eol}),
                        32'(held_m));
                end
                if (out_val && !out_rdy)
                    chk("rdy_stall", 32'(in3x3_rdy), 32'd0);
                if (out_val && out_rdy) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 32'(out_data), 32'hdead);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_mk", 32'({out_sof, out_eof, out_sol, out_eol}),
                            32'(e.m));
                    end
                end
                stall_prev = out_val && !out_rdy;
                held_d = out_data;
                held_m = {out_sof, out_eof, out_sol, out_eol};
            end
        end
    end

    initial begin : main
        int w0[9];
        int wf[9];
        int wz[9];
        logic [9*DW*C-1:0] d;
        w0 = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
        wf = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        wz = '{0, 0, 0, 0, 0, 0, 0, 0, 200};

        #2;
        chk("rst_val", 32'(out_val), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_mk", 32'({out_sof, out_eof, out_sol, out_eol}), 32'd0);
        chk("rst_mode", 32'(active_mode), 32'd0);
        chk("rst_rdy", 32'(in3x3_rdy), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Latency and median of the reference window.
        d = {pack9(w0), pack9(w0)};
        send(d, 4'b1010, 2'b00);
        chk("lat_s1", 32'(out_val), 32'd0);
        @(posedge clk); #1;
        chk("lat_s2", 32'(out_val), 32'd0);
        @(posedge clk); #1;
        chk("lat_s3", 32'(out_val), 32'd1);
        chk("median_ref", 32'(out_data[DW-1:0]), 32'd5);
        chk("sof_ref", 32'(out_sof), 32'd1);
        drain();

        // One-beat frames in min, max, bypass.
        send(d, 4'b1111, 2'b01);
        send(d, 4'b1111, 2'b10);
        send(d, 4'b1111, 2'b11);
        drain();

        // Saturated channel 0 with outlier in channel 1.
        d = {pack9(wz), pack9(wf)};
        send(d, 4'b1111, 2'b00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("two_ch", 32'(out_data), 32'h00ff);
        drain();

        // Mode change mid-frame only takes effect at the next sof.
        send(rnd_data(), 4'b1010, 2'b00);
        for (int i = 0; i < 3; i++) send(rnd_data(), 4'b0000, 2'b10);
        send(rnd_data(), 4'b0001, 2'b10);
        send(rnd_data(), 4'b1010, 2'b10);
        chk("mode_next", 32'(active_mode), 32'd2);
        send(rnd_data(), 4'b0101, 2'b00);
        drain();

        // Ten back-to-back beats with a four-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(rnd_data(), (i == 0) ? 4'b1010 : 4'b0000, 2'b01);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_rdy = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_rdy = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure.
        send_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(rnd_data(),
                         {($urandom_range(0, 7) == 0), 1'($urandom),
                          1'($urandom), 1'($urandom)},
                         2'($urandom));
                end
                send_done = 1'b1;
            end
            begin
                while (!send_done) begin
                    @(posedge clk);
                    #1 out_rdy = ($urandom_range(0, 2) != 0);
                end
                out_rdy = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        send(rnd_data(), 4'b1010, 2'b10);
        send(rnd_data(), 4'b0000, 2'b10);
        rst = 1'b1;
        #1;
        chk("mid_rst_val", 32'(out_val), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_mode", 32'(active_mode), 32'd0);
        sb.delete();
        cur_mode = 2'b00;
        @(posedge clk); #1;
        chk("mid_rst_rdy", 32'(in3x3_rdy), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale", 32'(out_val), 32'd0);
        end
        d = {pack9(w0), pack9(w0)};
        send(d, 4'b0000, 2'b11);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rank_filter_3x3.md
RANK_FILTER_3X3 -- requirements
Module: rank_filter_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per pixel sample.
REQ-002 SHALL have parameter CHANNELS, default 1, legal 1..4: independent 3x3 windows processed per beat.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port mode  input  2: 00 median, 01 minimum, 10 maximum, 11 bypass (centre pixel).
REQ-006 SHALL have port in3x3_val  input  1: upstream beat valid.
REQ-007 SHALL have port in3x3_rdy  output  1: block accepts beat.
REQ-008 SHALL have port in3x3_data  input  9*DATA_WIDTH*CHANNELS: channel c at bits [(c+1)*9*DW-1 : c*9*DW]; within a channel pixel p=row*3+col at [(p+1)*DW-1 : p*DW]; p4 is the centre.
REQ-009 SHALL have ports in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol  input  1 each: frame/line markers qualified by in3x3_val.
REQ-010 SHALL have port out_val  output  1: output beat valid.
REQ-011 SHALL have port out_rdy  input  1: downstream accepts beat.
REQ-012 SHALL have port out_data  output  DATA_WIDTH*CHANNELS: channel c result at [(c+1)*DW-1 : c*DW].
REQ-013 SHALL have ports out_sof, out_eof, out_sol, out_eol  output  1 each: markers aligned with out_data.
REQ-014 SHALL have port active_mode  output  2: mode currently applied to the frame in flight.

Function
REQ-015 SHALL transfer an input beat when in3x3_val && in3x3_rdy, and an output beat when out_val && out_rdy.
REQ-016 SHALL implement a 3-stage pipeline (S1 row sort, S2 column sort, S3 select); latency 3 cycles from input transfer to out_val with no stall.
REQ-017 SHALL advance all stages together with enable = !out_val || out_rdy; in3x3_rdy = enable; full throughput of 1 beat/cycle when out_rdy is held high.
REQ-018 SHALL hold out_data, markers and out_val stable while out_val && !out_rdy.
REQ-019 SHALL carry a valid bit per stage; bubbles (in3x3_val low while enabled) propagate as out_val=0.
REQ-020 S1 SHALL sort each of the 3 rows per channel into (min, mid, max).
REQ-021 S2 SHALL sort the min-column, mid-column and max-column of S1 results each into (min, mid, max).
REQ-022 S3 SHALL output per channel: median = median3(max of min-column, mid of mid-column, min of max-column); minimum = min of min-column; maximum = max of max-column; bypass = p4 delayed through the pipeline.
REQ-023 SHALL use unsigned comparison; equal values SHALL sort stably, with the result value independent of the tie order.
REQ-024 SHALL latch mode into active_mode when a beat with in3x3_sof=1 is transferred; mode changes at other times SHALL NOT affect frames in flight.
REQ-025 SHALL carry each beat's mode selection through the pipeline with its data, so that the last beats of frame N and the first beats of frame N+1 may coexist with different modes.
REQ-026 SHALL treat a beat with sof=1 and eof=1 as a one-beat frame; its mode is latched and applied.
REQ-027 SHALL delay the markers by exactly the data latency and output them unmodified.

Reset
REQ-028 While rst=1, the block SHALL hold out_val=0, out_data=0, all out markers=0, active_mode=00 (median), and all stage valids=0, asynchronously.
REQ-029 in3x3_rdy SHALL be 1 during and after reset (pipeline empty).
REQ-030 Reset asserted mid-frame SHALL discard all in-flight beats; after release the first output comes from the first beat accepted after release.

Verification
REQ-031 CHANNELS=1, mode=00, window p0..p8 = 9,1,8,2,7,3,6,4,5 with sof=1, out_rdy=1 -> out_data=5, out_sof=1, out_val high exactly 3 cycles after transfer.
REQ-032 Same window with mode=01, then mode=10, then mode=11, each sent as a one-beat frame -> outputs 1, 9, 7 in order, with active_mode tracking each frame.
REQ-033 CHANNELS=2: ch0 all 0xFF; ch1 = 0,0,0,0,0,0,0,0,200; mode=00 -> out_data = {0x00, 0xFF}.
REQ-034 10 back-to-back beats, out_rdy low for cycles 4..7 -> no beat lost or duplicated, out_data stable while stalled, in3x3_rdy low while the output is stalled and full.
REQ-035 mode changed from 00 to 10 on a non-sof beat mid-frame -> rest of the frame remains median; the next frame (sof) is max.
REQ-036 rst pulsed with 2 beats in flight -> out_val=0 immediately; no stale beat emitted after release.
